// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one full-adder cell plus a carry flop.
// Parallel operands in, registered parallel result out, start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sha_q;
  logic [WIDTH-1:0] shb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             s_d;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;

  // The single full-adder cell working on the current LSB pair.
  assign s_d     = sha_q[0] ^ shb_q[0] ^ carry_q;
  assign carry_d = (sha_q[0] & shb_q[0])
                 | (sha_q[0] & carry_q)
                 | (shb_q[0] & carry_q);
  assign res_d   = {s_d, res_q[WIDTH-1:1]};

  // Control FSM and serial datapath; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sha_q   <= a;
            shb_q   <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sha_q   <= {1'b0, sha_q[WIDTH-1:1]};
          shb_q   <= {1'b0, shb_q[WIDTH-1:1]};
          res_q   <= res_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // carry_q here is the carry into the MSB stage
            sum_q   <= res_d;
            cout_q  <= carry_d;
            ovf_q   <= carry_d ^ carry_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: WIDTH=8 directed vectors and WIDTH=2 sweep.
// Expected results are queued at start and popped at the done pulse.
module tb_serial_addsub;

  logic       clk;
  logic       rst_n;

  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic [7:0] sum8;
  logic       cout8, ovf8, busy8, done8;

  logic       start2, sub2;
  logic [1:0] a2, b2;
  logic [1:0] sum2;
  logic       cout2, ovf2, busy2, done2;

  int checks;
  int errors;

  logic [33:0] q8[$];
  logic [33:0] q2[$];

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .sub      (sub8),
    .a        (a8),
    .b        (b8),
    .sum      (sum8),
    .cout     (cout8),
    .overflow (ovf8),
    .busy     (busy8),
    .done     (done8)
  );

  serial_addsub #(.WIDTH(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .sub      (sub2),
    .a        (a2),
    .b        (b2),
    .sum      (sum2),
    .cout     (cout2),
    .overflow (ovf2),
    .busy     (busy2),
    .done     (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {overflow, cout, sum[31:0]} from wide integer arithmetic.
  function automatic logic [33:0] ref_op(
    input int w, input logic [31:0] a, input logic [31:0] b, input logic s
  );
    logic [32:0] m, av, bv, full, sm;
    logic co, ov;
    m    = (33'd1 << w) - 33'd1;
    av   = {1'b0, a} & m;
    bv   = s ? (~{1'b0, b}) & m : {1'b0, b} & m;
    full = av + bv + {32'd0, s};
    sm   = full & m;
    co   = full[w];
    ov   = (av[w-1] == bv[w-1]) && (sm[w-1] != av[w-1]);
    return {ov, co, sm[31:0]};
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0;
    start2 = 1'b1; a2 = 2'd1; b2 = 2'd1; sub2 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000) begin
        errors++;
        $display("FAIL reset8: got sum=%h c=%b v=%b busy=%b done=%b, want all 0",
                 sum8, cout8, ovf8, busy8, done8);
      end
      checks++;
      if ({sum2, cout2, ovf2, busy2, done2} !== 6'h00) begin
        errors++;
        $display("FAIL reset2: got sum=%h c=%b v=%b busy=%b done=%b, want all 0",
                 sum2, cout2, ovf2, busy2, done2);
      end
    end
    start8 = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  // One WIDTH=8 operation with latency, stability and result checks.
  // inj>0 pulses start with other operands at that RUN cycle.
  task automatic run8(
    input string nm, input logic [7:0] a, input logic [7:0] b,
    input logic s, input int inj
  );
    int busy_n, done_n, done_at;
    logic [7:0] held;
    logic [33:0] e;
    bit moved;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sub8 = s;
    q8.push_back(ref_op(8, {24'd0, a}, {24'd0, b}, s));
    held = sum8;
    busy_n = 0; done_n = 0; done_at = 0; moved = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (inj != 0 && k == inj) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0;
      end else begin
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      end
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (done_at == 0) done_at = k;
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL %s: unexpected done pulse at cycle %0d", nm, k);
        end else begin
          e = q8.pop_front();
          if ({ovf8, cout8, sum8} !== {e[33:32], e[7:0]}) begin
            errors++;
            $display("FAIL %s: got sum=%h c=%b v=%b, want sum=%h c=%b v=%b",
                     nm, sum8, cout8, ovf8, e[7:0], e[32], e[33]);
          end
        end
      end else if (done_at == 0 && sum8 !== held) begin
        moved = 1;
      end
    end
    start8 = 1'b0;
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL %s_hold: sum changed before done, want %h", nm, held);
    end
    checks++;
    if (done_n == 0) begin
      errors++;
      $display("FAIL %s_timeout: no done within 13 cycles, want done", nm);
      q8.delete();
    end else if (done_n != 1 || done_at != 9) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses at cycle %0d, want 1 at 9",
               nm, done_n, done_at);
    end
    checks++;
    if (busy_n != 8) begin
      errors++;
      $display("FAIL %s_busy: got %0d busy cycles, want 8", nm, busy_n);
    end
  endtask

  task automatic test_arith();
    run8("add_3c_15", 8'h3C, 8'h15, 1'b0, 0);
    run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 0);
    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 0);
    run8("sub_05_07", 8'h05, 8'h07, 1'b1, 0);
    run8("sub_80_01", 8'h80, 8'h01, 1'b1, 0);
    run8("sub_c8_c8", 8'hC8, 8'hC8, 1'b1, 0);
  endtask

  task automatic test_ignore_start();
    run8("ignore", 8'h10, 8'h20, 1'b0, 3);
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: busy=%b before reset, want 1", busy8);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b sum=%h, want 0 0 00",
               busy8, done8, sum8);
    end
    saw_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midrun_discard: busy/done seen after reset, want none");
    end
    q8.delete();
    run8("after_rst", 8'h01, 8'h02, 1'b0, 0);
  endtask

  task automatic test_sweep_w2();
    logic [33:0] e;
    int wait_n;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          @(negedge clk);
          start2 = 1'b1; a2 = 2'(a); b2 = 2'(b); sub2 = 1'(s);
          q2.push_back(ref_op(2, 32'(a), 32'(b), 1'(s)));
          @(negedge clk);
          start2 = 1'b0;
          wait_n = 0;
          while (!done2 && wait_n < 8) begin
            @(negedge clk);
            wait_n++;
          end
          checks++;
          if (!done2) begin
            errors++;
            $display("FAIL w2_timeout: a=%0d b=%0d sub=%0d no done", a, b, s);
            q2.delete();
          end else begin
            e = q2.pop_front();
            if ({ovf2, cout2, sum2} !== {e[33:32], e[1:0]} || wait_n != 2) begin
              errors++;
              $display("FAIL w2 a=%0d b=%0d sub=%0d: got sum=%b c=%b v=%b lat=%0d, want sum=%b c=%b v=%b lat=2",
                       a, b, s, sum2, cout2, ovf2, wait_n, e[1:0], e[32], e[33]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    test_reset();
    test_arith();
    test_ignore_start();
    test_reset_midrun();
    test_sweep_w2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
